timer_apb_master: RTL

APB requester that sits directly upstream of the 8-bit timer IP, converting single-beat CPU requests (register writes and reads of TDR 0x00, TCR 0x01, TSR 0x02) into APB setup/access transfers. It returns read data and error status on a one-cycle response strobe. A bounded wait-state counter guarantees that a stalled slave cannot hang the requester.

---
 rtl/timer_apb_master.sv | 118 +++++++++++
 1 files changed

// File: rtl/timer_apb_master.sv
// ============================================================================
// timer_apb_master : APB requester for the 8-bit timer IP.
//   Single-beat CPU write/read requests become APB setup/access transfers,
//   with a bounded wait-state counter so a stalled slave cannot hang it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic       TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       ready_en;
    logic       accept;
    logic       done_ok;
    logic       timed_out;

    assign accept    = cmd_valid & cmd_ready;
    assign done_ok   = (state == ACCESS) & pready;
    // Abort on the TIMEOUT-th consecutive stalled ACCESS cycle.
    assign timed_out = (state == ACCESS) & ~pready & TIMEOUT_EN
                       & ((wait_cnt + 8'd1) == TIMEOUT_C);

    // ready_en keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = ready_en & (state == IDLE);
    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done_ok || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ready_en  <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            wait_cnt  <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            rsp_valid <= done_ok | timed_out;

            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end

            if (state == SETUP) begin
                wait_cnt <= 8'd0;
            end else if ((state == ACCESS) && !pready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (done_ok) begin
                rsp_err   <= pslverr;
                rsp_rdata <= pwrite ? '0 : prdata;
            end else if (timed_out) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

`default_nettype wire
